// File: rtl/unidade_controle_rodadas_pkg.sv
// State codes for the round-based memory game control unit, shared by the
// FSM and by anything that decodes db_estado for the display.
package unidade_controle_rodadas_pkg;

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIA_RODADA  = 4'h2,
    ESPERA_JOGADA  = 4'h3,
    REGISTRA       = 4'h4,
    COMPARACAO     = 4'h5,
    PROXIMO        = 4'h6,
    PROXIMA_RODADA = 4'h7,
    FINAL_ACERTO   = 4'hA,
    FINAL_ERRO     = 4'hB,
    FINAL_TIMEOUT  = 4'hD
  } estado_t;

  // Shown on the display if the state register ever holds an unused code.
  localparam logic [3:0] DB_ESTADO_ILEGAL = 4'hE;

endpackage

// File: rtl/unidade_controle_rodadas_contador_timeout.sv
// Per-move timeout timer: counts cycles while 'conta' is high, clears on
// 'zera', and saturates at M-1 instead of wrapping. 'fim' flags M-1.
module contador_timeout #(
  parameter int M = 5000
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int W = (M > 1) ? $clog2(M) : 1;
  localparam logic [W-1:0] ULTIMO = W'(M - 1);

  logic [W-1:0] valor_q, valor_d;

  // Next count: clear has priority, otherwise increment until terminal count.
  always_comb begin
    // NOTE: default assignment first so every path drives valor_d (no latch).
    valor_d = valor_q;
    if (zera) begin
      valor_d = '0;
    end else if (conta && (valor_q != ULTIMO)) begin
      valor_d = valor_q + W'(1);
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: non-blocking assignments for all clocked state.
    if (reset) valor_q <= '0;
    else       valor_q <= valor_d;
  end

  assign fim = (valor_q == ULTIMO);

endmodule

// File: rtl/unidade_controle_rodadas.sv
// Moore control unit for the round-based memory game: sequences the address,
// round and move registers and enforces a per-move timeout.
module unidade_controle_rodadas
  import unidade_controle_rodadas_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       enderecoIgualRodada,
  input  logic       fimR,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraR,
  output logic       contaR,
  output logic       zeraRJ,
  output logic       registraRJ,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic       pronto,
  output logic [3:0] db_estado
);

  estado_t estado_q, estado_d;
  logic    timer_zera, timer_conta, timer_fim;

  // The timer only runs while waiting for a move; any other state clears it.
  assign timer_conta = (estado_q == ESPERA_JOGADA);
  assign timer_zera  = ~timer_conta;

  contador_timeout #(
    .M(TIMEOUT_CICLOS)
  ) u_contador_timeout (
    .clock (clock),
    .reset (reset),
    .zera  (timer_zera),
    .conta (timer_conta),
    .fim   (timer_fim)
  );

  // State register; reset forces inicial immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado_q <= INICIAL;
    else       estado_q <= estado_d;
  end

  // Next-state logic; a move wins over a simultaneous timeout.
  always_comb begin
    estado_d = INICIAL;
    case (estado_q)
      INICIAL:        estado_d = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:     estado_d = INICIA_RODADA;
      INICIA_RODADA:  estado_d = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        if (jogada)         estado_d = REGISTRA;
        else if (timer_fim) estado_d = FINAL_TIMEOUT;
        else                estado_d = ESPERA_JOGADA;
      end
      REGISTRA:       estado_d = COMPARACAO;
      COMPARACAO: begin
        if (!igual)                    estado_d = FINAL_ERRO;
        else if (!enderecoIgualRodada) estado_d = PROXIMO;
        else if (!fimR)                estado_d = PROXIMA_RODADA;
        else                           estado_d = FINAL_ACERTO;
      end
      PROXIMO:        estado_d = ESPERA_JOGADA;
      PROXIMA_RODADA: estado_d = INICIA_RODADA;
      FINAL_ACERTO, FINAL_ERRO, FINAL_TIMEOUT:
                      estado_d = iniciar ? PREPARACAO : estado_q;
      default:        estado_d = INICIAL;
    endcase
  end

  // Moore output decode from the current state only.
  always_comb begin
    zeraE      = 1'b0;
    contaE     = 1'b0;
    zeraR      = 1'b0;
    contaR     = 1'b0;
    zeraRJ     = 1'b0;
    registraRJ = 1'b0;
    acertou    = 1'b0;
    errou      = 1'b0;
    timeout    = 1'b0;
    pronto     = 1'b0;
    db_estado  = estado_q;
    case (estado_q)
      INICIAL, PREPARACAO: begin
        zeraE  = 1'b1;
        zeraR  = 1'b1;
        zeraRJ = 1'b1;
      end
      INICIA_RODADA:  zeraE      = 1'b1;
      ESPERA_JOGADA:  ;
      REGISTRA:       registraRJ = 1'b1;
      COMPARACAO:     ;
      PROXIMO:        contaE     = 1'b1;
      PROXIMA_RODADA: contaR     = 1'b1;
      FINAL_ACERTO: begin
        acertou = 1'b1;
        pronto  = 1'b1;
      end
      FINAL_ERRO: begin
        errou  = 1'b1;
        pronto = 1'b1;
      end
      FINAL_TIMEOUT: begin
        timeout = 1'b1;
        pronto  = 1'b1;
      end
      default:        db_estado  = DB_ESTADO_ILEGAL;
    endcase
  end

endmodule
